// File: rtl/sled_scan_counter.sv
// sled_scan_counter
// Hex up/down counter driving a multiplexed, common-anode 7-segment display.
// A prescaler turns the board clock into count steps. A separate free-running
// scan counter selects one digit at a time, so each digit can show its own nibble.
//
// Ports
//   clock      : system clock, every flop updates on its rising edge
//   reset      : synchronous, active-high
//   enable     : 1 runs the count prescaler; 0 pauses counting (scanning keeps going)
//   up_down    : 1 counts up, 0 counts down
//   load       : single-cycle strobe that copies load_value into the counter
//   load_value : parallel load data, 4*NUM_DIGITS bits
//   blank_lz   : 1 blanks leading zero digits (digit 0 is always shown)
//   dp_mask    : bit i lights the decimal point of digit i
//   segs       : {dp,g,f,e,d,c,b,a}, active-low, registered
//   digs       : digit selects, active-low, registered; digit 0 is the least significant nibble
//   value      : current count, registered
//   wrap       : single-cycle pulse when the count wraps around
module sled_scan_counter #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 50_000_000,
   parameter int SCAN_DIV   = 50_000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      up_down,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_value,
   input  logic                      blank_lz,
   input  logic [NUM_DIGITS-1:0]     dp_mask,
   output logic [7:0]                segs,
   output logic [NUM_DIGITS-1:0]     digs,
   output logic [4*NUM_DIGITS-1:0]   value,
   output logic                      wrap
);

   localparam int VW = 4 * NUM_DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [VW-1:0]         value_q, value_d;
   logic                  wrap_q, wrap_d;
   logic [7:0]            segs_q, segs_d;
   logic [NUM_DIGITS-1:0] digs_q, digs_d;

   logic                  tick;
   logic                  scan_last;
   logic [3:0]            nibble;
   logic                  upper_zero;
   logic                  blanked;
   logic [7:0]            glyph;

   // Active-low segment pattern for one hex nibble, decimal point off.
   function automatic logic [7:0] decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Prescaler and counter. Load beats everything except reset, and it also
   // restarts the prescaler so the next step is a full period away.
   always_comb begin
      tick    = enable && (presc_q == PRESC_LAST);
      presc_d = presc_q;
      value_d = value_q;
      wrap_d  = 1'b0;
      if (load) begin
         value_d = load_value;
         presc_d = '0;
      end else if (enable) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (up_down) begin
               value_d = value_q + VW'(1);
               wrap_d  = (value_q == {VW{1'b1}});
            end else begin
               value_d = value_q - VW'(1);
               wrap_d  = (value_q == '0);
            end
         end
      end
   end

   // Digit scanning. The cycle in which the index steps is a dead cycle with
   // everything dark, so the old digit's segments never flash on the new digit.
   always_comb begin
      scan_last = (scan_q == SCAN_LAST);
      scan_d    = scan_last ? '0 : scan_q + SW'(1);
      idx_d     = idx_q;
      if (scan_last) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end

      nibble     = value_q[4*int'(idx_q) +: 4];
      upper_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if ((j >= int'(idx_q)) && (value_q[4*j +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
         end
      end
      blanked = blank_lz && (idx_q != '0) && upper_zero;

      glyph = decode(nibble);
      if (dp_mask[idx_q]) begin
         glyph[7] = 1'b0;
      end
      if (blanked) begin
         glyph = 8'hFF;
      end

      if (scan_last) begin
         segs_d = 8'hFF;
         digs_d = {NUM_DIGITS{1'b1}};
      end else begin
         segs_d = glyph;
         digs_d = ~(NUM_DIGITS'(1) << idx_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         value_q <= '0;
         wrap_q  <= 1'b0;
         segs_q  <= 8'hFF;
         digs_q  <= {NUM_DIGITS{1'b1}};
      end else begin
         presc_q <= presc_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         value_q <= value_d;
         wrap_q  <= wrap_d;
         segs_q  <= segs_d;
         digs_q  <= digs_d;
      end
   end

   assign segs  = segs_q;
   assign digs  = digs_q;
   assign value = value_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_sled_scan_counter.sv
// Testbench for sled_scan_counter with NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=3.
// A behavioural model advances once per clock and pushes the outputs it
// expects into a queue; each test task pops and compares after the edge.
module tb_sled_scan_counter;

   localparam int ND = 4;
   localparam int TD = 4;
   localparam int SD = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        up_down = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_value = 16'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  dp_mask = 4'h0;
   logic [7:0]  segs;
   logic [3:0]  digs;
   logic [15:0] value;
   logic        wrap;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [15:0] value;
      logic        wrap;
      logic [3:0]  digs;
      logic [7:0]  segs;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // model state
   logic [15:0] m_value = 16'h0;
   int          m_presc = 0;
   int          m_scan = 0;
   int          m_idx = 0;

   sled_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
      .load(load), .load_value(load_value), .blank_lz(blank_lz), .dp_mask(dp_mask),
      .segs(segs), .digs(digs), .value(value), .wrap(wrap)
   );

   always #5 clock = ~clock;

   // Advance the model by one clock using the inputs currently driven, queue
   // the expected outputs, then let the DUT take the same edge.
   task automatic step();
      exp_t        x;
      logic [15:0] nv;
      logic [15:0] shifted;
      int          np, nsc, ni;
      logic        nw, tk, term, blank;
      if (reset) begin
         nv = 16'h0; np = 0; nsc = 0; ni = 0; nw = 1'b0;
         x.digs = 4'hF; x.segs = 8'hFF;
      end else begin
         tk = enable && (m_presc == TD - 1);
         nv = m_value; np = m_presc; nw = 1'b0;
         if (load) begin
            nv = load_value; np = 0;
         end else if (enable) begin
            np = tk ? 0 : m_presc + 1;
            if (tk && up_down) begin
               nv = m_value + 16'd1; nw = (m_value == 16'hFFFF);
            end else if (tk) begin
               nv = m_value - 16'd1; nw = (m_value == 16'h0000);
            end
         end
         term = (m_scan == SD - 1);
         nsc = term ? 0 : m_scan + 1;
         ni = term ? (m_idx + 1) % ND : m_idx;
         shifted = m_value >> (4 * m_idx);
         blank = blank_lz && (m_idx != 0) && (shifted == 16'h0);
         if (term) begin
            x.digs = 4'hF; x.segs = 8'hFF;
         end else begin
            x.digs = ~(4'b0001 << m_idx);
            x.segs = blank ? 8'hFF : (dec_tab[shifted[3:0]] & (dp_mask[m_idx] ? 8'h7F : 8'hFF));
         end
      end
      x.value = nv; x.wrap = nw;
      exp_q.push_back(x);
      m_value = nv; m_presc = np; m_scan = nsc; m_idx = ni;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] seq [12] = '{4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hF, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'hF};
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         e = exp_q.pop_front();
         tests_run++; if (value !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_value got %h want 0000", value); end
         tests_run++; if (segs !== 8'hFF) begin tests_failed++; $display("[TB] FAIL reset_segs got %h want FF", segs); end
         tests_run++; if (digs !== 4'hF) begin tests_failed++; $display("[TB] FAIL reset_digs got %h want F", digs); end
         tests_run++; if (wrap !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wrap got %b want 0", wrap); end
      end
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         e = exp_q.pop_front();
         tests_run++; if (digs !== seq[k]) begin tests_failed++; $display("[TB] FAIL scan_seq[%0d] got %h want %h", k, digs, seq[k]); end
         tests_run++; if (segs !== e.segs) begin tests_failed++; $display("[TB] FAIL scan_segs got %h want %h", segs, e.segs); end
      end
   endtask

   task automatic test_count_up();
      enable = 1'b1; up_down = 1'b1;
      load = 1'b1; load_value = 16'hFFFE;
      step(); e = exp_q.pop_front();
      load = 1'b0;
      tests_run++; if (value !== 16'hFFFE) begin tests_failed++; $display("[TB] FAIL up_load got %h want FFFE", value); end
      for (int k = 1; k <= 9; k++) begin
         step(); e = exp_q.pop_front();
         tests_run++; if (value !== e.value) begin tests_failed++; $display("[TB] FAIL up_value got %h want %h", value, e.value); end
         tests_run++; if (wrap !== e.wrap) begin tests_failed++; $display("[TB] FAIL up_wrap got %b want %b", wrap, e.wrap); end
         tests_run++; if (digs !== e.digs || segs !== e.segs) begin tests_failed++; $display("[TB] FAIL up_disp got %h/%h want %h/%h", digs, segs, e.digs, e.segs); end
         if (k == 4) begin
            tests_run++; if (value !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL up_ffff got %h want FFFF", value); end
         end
         if (k == 8) begin
            tests_run++; if (value !== 16'h0000 || wrap !== 1'b1) begin tests_failed++; $display("[TB] FAIL up_wrap_pulse got %h/%b want 0000/1", value, wrap); end
         end
         if (k == 9) begin
            tests_run++; if (wrap !== 1'b0) begin tests_failed++; $display("[TB] FAIL up_wrap_end got %b want 0", wrap); end
         end
      end
   endtask

   task automatic test_count_down();
      logic        saw_wrap = 1'b0;
      logic [15:0] frozen;
      int          dig_changes = 0;
      logic [3:0]  last_digs;
      up_down = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(); e = exp_q.pop_front();
         if (wrap === 1'b1) saw_wrap = 1'b1;
         tests_run++; if (value !== e.value || wrap !== e.wrap) begin tests_failed++; $display("[TB] FAIL down got %h/%b want %h/%b", value, wrap, e.value, e.wrap); end
      end
      tests_run++; if (value !== 16'hFFFF || !saw_wrap) begin tests_failed++; $display("[TB] FAIL down_wrap got %h wrap_seen=%b want FFFF wrap_seen=1", value, saw_wrap); end
      enable = 1'b0;
      frozen = value;
      last_digs = digs;
      for (int k = 0; k < 20; k++) begin
         step(); e = exp_q.pop_front();
         if (digs !== last_digs) dig_changes++;
         last_digs = digs;
         tests_run++; if (value !== frozen) begin tests_failed++; $display("[TB] FAIL paused_value got %h want %h", value, frozen); end
         tests_run++; if (digs !== e.digs || segs !== e.segs) begin tests_failed++; $display("[TB] FAIL paused_disp got %h/%h want %h/%h", digs, segs, e.digs, e.segs); end
      end
      tests_run++; if (dig_changes < 10) begin tests_failed++; $display("[TB] FAIL paused_scan got %0d digit changes want >=10", dig_changes); end
   endtask

   task automatic test_load_tick();
      int guard = 0;
      enable = 1'b1; up_down = 1'b1;
      while (m_presc != TD - 1 && guard < 10) begin
         step(); e = exp_q.pop_front(); guard++;
         tests_run++; if (value !== e.value) begin tests_failed++; $display("[TB] FAIL pre_load got %h want %h", value, e.value); end
      end
      tests_run++; if (m_presc != TD - 1) begin tests_failed++; $display("[TB] FAIL load_tick_align got presc %0d want %0d", m_presc, TD - 1); end
      load = 1'b1; load_value = 16'h1234;
      step(); e = exp_q.pop_front();
      load = 1'b0;
      tests_run++; if (value !== 16'h1234 || wrap !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_tick got %h/%b want 1234/0", value, wrap); end
      for (int k = 1; k <= 4; k++) begin
         step(); e = exp_q.pop_front();
         tests_run++; if (value !== ((k < 4) ? 16'h1234 : 16'h1235)) begin tests_failed++; $display("[TB] FAIL after_load[%0d] got %h want %h", k, value, (k < 4) ? 16'h1234 : 16'h1235); end
      end
   endtask

   task automatic test_blanking();
      logic [7:0] seen [4];
      logic [7:0] want [4];
      for (int pass = 0; pass < 2; pass++) begin
         enable = 1'b0; blank_lz = 1'b1; dp_mask = 4'h0;
         load = 1'b1; load_value = (pass == 0) ? 16'h0050 : 16'h0000;
         step(); e = exp_q.pop_front();
         load = 1'b0;
         for (int d = 0; d < 4; d++) seen[d] = 8'h00;
         for (int k = 0; k < 14; k++) begin
            step(); e = exp_q.pop_front();
            tests_run++; if (digs !== e.digs || segs !== e.segs) begin tests_failed++; $display("[TB] FAIL blank_disp got %h/%h want %h/%h", digs, segs, e.digs, e.segs); end
            for (int d = 0; d < 4; d++) if (digs === ~(4'b0001 << d)) seen[d] = segs;
         end
         want = (pass == 0) ? '{8'hC0, 8'h92, 8'hFF, 8'hFF} : '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
         for (int d = 0; d < 4; d++) begin
            tests_run++; if (seen[d] !== want[d]) begin tests_failed++; $display("[TB] FAIL blank_digit%0d pass%0d got %h want %h", d, pass, seen[d], want[d]); end
         end
      end
   endtask

   task automatic test_dp_and_reset();
      logic [7:0] seen1 = 8'h00;
      blank_lz = 1'b0; dp_mask = 4'b0010;
      load = 1'b1; load_value = 16'h0007;
      step(); e = exp_q.pop_front();
      load = 1'b0;
      for (int k = 0; k < 14; k++) begin
         step(); e = exp_q.pop_front();
         tests_run++; if (segs !== e.segs) begin tests_failed++; $display("[TB] FAIL dp_segs got %h want %h", segs, e.segs); end
         if (digs === 4'b1101) seen1 = segs;
      end
      tests_run++; if (seen1 !== 8'h40) begin tests_failed++; $display("[TB] FAIL dp_digit1 got %h want 40", seen1); end
      enable = 1'b1;
      step(); e = exp_q.pop_front();
      reset = 1'b1;
      step(); e = exp_q.pop_front();
      reset = 1'b0;
      tests_run++; if (value !== 16'h0 || segs !== 8'hFF || digs !== 4'hF || wrap !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL midscan_reset got %h/%h/%h/%b want 0000/FF/F/0", value, segs, digs, wrap);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 400; k++) begin
         load = ($urandom_range(0, 15) == 0);
         load_value = (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'(($urandom_range(0, 3) == 0) ? 0 : $urandom));
         if (k % 16 == 0) begin
            up_down = $urandom_range(0, 1);
            blank_lz = $urandom_range(0, 1);
            dp_mask = 4'($urandom);
         end
         enable = ($urandom_range(0, 7) != 0);
         reset = ($urandom_range(0, 99) == 0);
         step(); e = exp_q.pop_front();
         tests_run++; if (value !== e.value || wrap !== e.wrap || digs !== e.digs || segs !== e.segs) begin
            tests_failed++; $display("[TB] FAIL random[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", k, value, wrap, digs, segs, e.value, e.wrap, e.digs, e.segs);
         end
      end
      reset = 1'b0; load = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_count_up();
      test_count_down();
      test_load_tick();
      test_blanking();
      test_dp_and_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
